otter_cu_fsm: RTL

//  Multicycle sequencer for the OTTER core: steps each instruction through fetch, execute, load writeback
//  and interrupt entry. Drives PC/regfile/memory/CSR enables around the combinational control decoder
//  (which supplies mux selects). Sits beside the decoder, between core top level, memory and CSR file.

---
 rtl/otter_cu_fsm_if.sv | 29 ++
 rtl/otter_cu_fsm.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/otter_cu_fsm_if.sv
// Control bundle between the OTTER multicycle sequencer and the rest of the core.
// master = sequencer (drives enables), slave = core top / memory / CSR side.
interface otter_cu_fsm_if;
  logic [6:0] ir6_0;
  logic [2:0] ir14_12;
  logic       mem_ack;
  logic       intr;
  logic       int_en;

  logic       cpu_rst;
  logic       pc_write;
  logic       reg_write;
  logic       mem_rden1;
  logic       mem_rden2;
  logic       mem_we2;
  logic       csr_we;
  logic       int_taken;
  logic       mret_exec;

  modport master (
    input  ir6_0, ir14_12, mem_ack, intr, int_en,
    output cpu_rst, pc_write, reg_write, mem_rden1, mem_rden2, mem_we2, csr_we, int_taken, mret_exec
  );

  modport slave (
    output ir6_0, ir14_12, mem_ack, intr, int_en,
    input  cpu_rst, pc_write, reg_write, mem_rden1, mem_rden2, mem_we2, csr_we, int_taken, mret_exec
  );
endinterface

// File: rtl/otter_cu_fsm.sv
// OTTER multicycle sequencer: INIT -> FETCH -> EXEC [-> WB] [-> INTR]; interrupt path under OTTER_CU_INTR_EN.
// Latency: 2 cycles per instruction, 3+N for loads (N = mem_ack wait cycles), +1 on interrupt entry.
// Backpressure: WB holds with mem_rden2 asserted until mem_ack; no timeout.
module otter_cu_fsm #(
  parameter int INIT_CYCLES = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  otter_cu_fsm_if.master cu
);

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WB    = 3'd3,
    ST_INTR  = 3'd4
  } state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_SYS   = 7'b1110011;

  localparam logic [2:0] F3_CSRRW = 3'b001;
  localparam logic [2:0] F3_MRET  = 3'b000;

  localparam logic [3:0] INIT_LAST = 4'(INIT_CYCLES - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       irq_go;

  logic cpu_rst_c, pc_write_c, reg_write_c, mem_rden1_c, mem_rden2_c;
  logic mem_we2_c, csr_we_c, int_taken_c, mret_exec_c;

`ifdef OTTER_CU_INTR_EN
  assign irq_go = cu.intr & cu.int_en;
`else
  logic unused_irq_inputs;
  assign unused_irq_inputs = cu.intr ^ cu.int_en;
  assign irq_go            = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cpu_rst_c   = 1'b0;
    pc_write_c  = 1'b0;
    reg_write_c = 1'b0;
    mem_rden1_c = 1'b0;
    mem_rden2_c = 1'b0;
    mem_we2_c   = 1'b0;
    csr_we_c    = 1'b0;
    int_taken_c = 1'b0;
    mret_exec_c = 1'b0;

    unique case (state_q)
      ST_INIT: begin
        cpu_rst_c = 1'b1;
        if (cnt_q >= INIT_LAST) begin
          cnt_d   = '0;
          state_d = ST_FETCH;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      ST_FETCH: begin
        mem_rden1_c = 1'b1;
        state_d     = ST_EXEC;
      end

      ST_EXEC: begin
        state_d = irq_go ? ST_INTR : ST_FETCH;
        case (cu.ir6_0)
          OP_R, OP_I, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: begin
            pc_write_c  = 1'b1;
            reg_write_c = 1'b1;
          end
          OP_BR: pc_write_c = 1'b1;
          OP_ST: begin
            pc_write_c = 1'b1;
            mem_we2_c  = 1'b1;
          end
          OP_LD: begin
            // Load data arrives later; the PC only moves once it is written back.
            mem_rden2_c = 1'b1;
            state_d     = ST_WB;
          end
          OP_SYS: begin
            pc_write_c = 1'b1;
            if (cu.ir14_12 == F3_CSRRW) begin
              reg_write_c = 1'b1;
              csr_we_c    = 1'b1;
            end
`ifdef OTTER_CU_INTR_EN
            if (cu.ir14_12 == F3_MRET) begin
              mret_exec_c = 1'b1;
            end
`endif
          end
          default: pc_write_c = 1'b1;
        endcase
      end

      ST_WB: begin
        mem_rden2_c = 1'b1;
        if (cu.mem_ack) begin
          reg_write_c = 1'b1;
          pc_write_c  = 1'b1;
          state_d     = irq_go ? ST_INTR : ST_FETCH;
        end
      end

      ST_INTR: begin
`ifdef OTTER_CU_INTR_EN
        int_taken_c = 1'b1;
        pc_write_c  = 1'b1;
`endif
        state_d = ST_FETCH;
      end

      default: state_d = ST_FETCH;
    endcase
  end

  // Architectural write enables are held off combinationally while reset is asserted.
  assign cu.cpu_rst   = cpu_rst_c;
  assign cu.pc_write  = pc_write_c  & rst_n;
  assign cu.reg_write = reg_write_c & rst_n;
  assign cu.mem_rden1 = mem_rden1_c;
  assign cu.mem_rden2 = mem_rden2_c;
  assign cu.mem_we2   = mem_we2_c   & rst_n;
  assign cu.csr_we    = csr_we_c    & rst_n;
  assign cu.int_taken = int_taken_c;
  assign cu.mret_exec = mret_exec_c;

  a_pc_write_spacing: assert property (@(posedge clk)
    cu.pc_write |=> (!cu.pc_write || state_q == ST_INTR));
  a_store_only_in_exec: assert property (@(posedge clk) disable iff (!rst_n)
    cu.mem_we2 |-> state_q == ST_EXEC);
  a_init_only_cpu_rst: assert property (@(posedge clk)
    cu.cpu_rst |-> !(cu.pc_write || cu.reg_write || cu.mem_rden1 || cu.mem_rden2));

endmodule
